// File: rtl/cpu_decode_queue.sv
// RV32 decode queue: instructions are decoded on push and the decoded fields
// are stored alongside the raw word, so the head presents registered fields.
module cpu_decode_queue #(
    parameter int unsigned DEPTH         = 4,
    parameter bit          STRICT_DECODE = 1'b1
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_valid,
    input  logic [31:0]                  i_instruction,
    input  logic [31:0]                  i_pc,
    output logic                         o_ready,
    input  logic                         i_flush,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [31:0]                  o_instruction,
    output logic [31:0]                  o_pc,
    output logic [4:0]                   o_inst_rs1,
    output logic [4:0]                   o_inst_rs2,
    output logic [4:0]                   o_inst_rd,
    output logic [31:0]                  o_imm,
    output logic [2:0]                   o_format,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        FMT_R       = 3'd0,
        FMT_I       = 3'd1,
        FMT_S       = 3'd2,
        FMT_B       = 3'd3,
        FMT_U       = 3'd4,
        FMT_J       = 3'd5,
        FMT_INVALID = 3'd7
    } format_t;

    logic [31:0] r_inst_mem [DEPTH];
    logic [31:0] r_pc_mem   [DEPTH];
    logic [31:0] r_imm_mem  [DEPTH];
    format_t     r_fmt_mem  [DEPTH];

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    format_t     w_fmt;
    logic [31:0] w_imm;
    logic        w_push;
    logic        w_pop;

    always_comb begin
        w_fmt = STRICT_DECODE ? FMT_INVALID : FMT_I;
        case (i_instruction[6:0])
            7'b0110011:                                     w_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: w_fmt = FMT_I;
            7'b0100011:                                     w_fmt = FMT_S;
            7'b1100011:                                     w_fmt = FMT_B;
            7'b0110111, 7'b0010111:                         w_fmt = FMT_U;
            7'b1101111:                                     w_fmt = FMT_J;
            default:                                        ;
        endcase
    end

    always_comb begin
        w_imm = '0;
        case (w_fmt)
            FMT_I: w_imm = {{20{i_instruction[31]}}, i_instruction[31:20]};
            FMT_S: w_imm = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
            FMT_B: w_imm = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                            i_instruction[30:25], i_instruction[11:8], 1'b0};
            FMT_U: w_imm = {i_instruction[31:12], 12'b0};
            FMT_J: w_imm = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                            i_instruction[20], i_instruction[30:21], 1'b0};
            default: w_imm = '0;
        endcase
    end

    assign o_ready = (r_count != CW'(DEPTH));
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    assign w_push = i_valid & o_ready & ~i_flush;
    assign w_pop  = o_valid & i_ready & ~i_flush;

    // Storage is deliberately left out of reset; only occupancy state is cleared.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= i_instruction;
            r_pc_mem[r_wr_ptr]   <= i_pc;
            r_imm_mem[r_wr_ptr]  <= w_imm;
            r_fmt_mem[r_wr_ptr]  <= w_fmt;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_instruction = r_inst_mem[r_rd_ptr];
    assign o_pc          = r_pc_mem[r_rd_ptr];
    assign o_imm         = r_imm_mem[r_rd_ptr];
    assign o_format      = r_fmt_mem[r_rd_ptr];
    assign o_inst_rs1    = o_instruction[19:15];
    assign o_inst_rs2    = o_instruction[24:20];
    assign o_inst_rd     = o_instruction[11:7];

endmodule
